digit_scan_ctrl: RTL
====================

// Module: digit_scan_ctrl
// PURPOSE
//  Upstream driver for the 2-to-4 active-low digit decoder in the 4-digit display path.
//  Time-multiplexes four digits: a 2-bit select drives the decoder A/B inputs and an
//  active-low enable drives its E input. Each digit is lit for PRESCALE cycles, then
//  blanked for BLANK cycles. The select changes only while the enable is high, so the
//  decoder outputs never glitch. Digits cleared in a mask are skipped.
// PARAMETERS
//  PRESCALE  1000  clock cycles a digit is lit (en_n=0); legal range >=2
//  BLANK     16    dead-time cycles between digits (en_n=1); legal range >=2
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  run         in   1  1 = scanning enabled
//  digit_mask  in   4  bit i=1 means digit i is included in the scan
//  sel         out  2  digit index; sel[1] feeds decoder A, sel[0] feeds decoder B
//  en_n        out  1  active-low enable; feeds decoder E
//  frame_tick  out  1  one-cycle pulse when the scan wraps to a new frame
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, sel=0, en_n=1, frame_tick=0, counters=0.
//  All outputs are registered. Counter widths: $clog2(PRESCALE) and $clog2(BLANK), min 1.
//  nxt(s): next set mask bit above s in ascending order, wrapping 3->0.
//    If s is the only set bit, nxt(s)=s.
//  IDLE: en_n=1, sel held.
//    Leave when run=1 and digit_mask!=0: next edge enters ON with
//    sel=lowest set mask bit and en_n=0. No frame_tick on this entry.
//  ON: en_n=0 for exactly PRESCALE cycles, then go to BLANK with en_n=1 and sel held.
//    If digit_mask[sel] clears during ON, go to BLANK at the next edge (early end).
//  BLANK: en_n=1 for exactly BLANK cycles.
//    At the edge that ends the first BLANK cycle, sel<=nxt(sel), using digit_mask
//    sampled at that edge.
//    If the new sel is <= the old sel (wrap, or a single digit), frame_tick=1 for the
//    cycle in which the new sel first appears.
//    At the edge that ends the last BLANK cycle, return to ON with en_n=0.
//  Digit period = PRESCALE+BLANK cycles; full 4-digit frame = 4*(PRESCALE+BLANK).
//  Abort: run=0 or digit_mask==0 sampled in ON or BLANK -> next edge: IDLE, en_n=1,
//    sel held, counters cleared. Abort has priority over every other transition.
//  If mask==0 when nxt() is evaluated, the abort fires instead and sel holds.
//  Never: en_n=0 in the same cycle sel changes; frame_tick high for more than 1 cycle.
//  Async reset mid-ON forces en_n=1 immediately, with no clock required.
//  Restarting from IDLE always begins at the lowest set digit.
// TESTING (PRESCALE=4, BLANK=2 unless stated)
//  1 Reset: rst_n=0 -> sel=0, en_n=1, frame_tick=0, all without a clock edge;
//    hold run=0 for 10 cycles -> outputs unchanged.
//  2 mask=1111, run=1:
//    - sel sequence 0,1,2,3,0; en_n low 4 cycles, high 2 cycles, per digit;
//    - sel changes only on the 2nd blank cycle; frame_tick high 1 cycle as sel goes 3->0;
//    - frame_tick period 24 cycles.
//  3 mask=0101 -> sel alternates 0,2,0,2; frame_tick on each 2->0 change.
//    mask=1000 -> sel stays 3 and frame_tick fires every 6 cycles.
//  4 run drops on the 2nd ON cycle of digit 1 -> en_n=1 next edge, IDLE, sel=1 held;
//    run=1 again -> restart at sel=0.
//  5 Clear digit_mask[2] while sel=2 in ON -> early BLANK next edge, next sel=3;
//    clear all mask bits in BLANK -> IDLE.
//  6 Async rst_n pulse mid-ON (between edges) -> en_n=1 at once;
//    after release, run=1 restarts cleanly at sel=0.
//    Also run PRESCALE=1000, BLANK=16 -> 4064-cycle frame_tick period.

Source files
------------

// File: rtl/digit_scan_if.sv
// Digit scan bus: run/mask controls in, decoder select/enable and frame pulse out.
interface digit_scan_if;
  logic       run;
  logic [3:0] digit_mask;
  logic [1:0] sel;
  logic       en_n;
  logic       frame_tick;

  // Driver side: owns run/mask and observes the decoder-facing outputs.
  modport master (
    output run,
    output digit_mask,
    input  sel,
    input  en_n,
    input  frame_tick
  );

  // Scan controller side.
  modport slave (
    input  run,
    input  digit_mask,
    output sel,
    output en_n,
    output frame_tick
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner feeding a 2-to-4 active-low decoder.
// Each enabled digit is lit PRESCALE cycles, then blanked BLANK cycles; the
// select only moves while the decoder enable is deasserted.
module digit_scan_ctrl #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned BLANK    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  digit_scan_if.slave  bus
);

  localparam int unsigned ON_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BL_W = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [ON_W-1:0] ON_LAST = ON_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLANK - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic            en_n_q, en_n_d;
  logic            tick_q, tick_d;
  logic [ON_W-1:0] on_cnt_q, on_cnt_d;
  logic [BL_W-1:0] blk_cnt_q, blk_cnt_d;

  logic            abort_c;
  logic [1:0]      nxt_sel_c;
  logic [1:0]      low_sel_c;

  // Next set mask bit above s, wrapping 3->0; s itself if it is the only one.
  function automatic logic [1:0] next_digit(input logic [1:0] s, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = s;
    found = 1'b0;
    for (int k = 1; k < 4; k++) begin
      idx = s + 2'(k);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Lowest set mask bit (0 when mask is empty; unused in that case).
  function automatic logic [1:0] lowest_digit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) r = 2'(k);
    end
    return r;
  endfunction

  assign abort_c   = !bus.run || (bus.digit_mask == 4'b0000);
  assign nxt_sel_c = next_digit(sel_q, bus.digit_mask);
  assign low_sel_c = lowest_digit(bus.digit_mask);

  // State, select, enable, pulse and dwell counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'd0;
      en_n_q    <= 1'b1;
      tick_q    <= 1'b0;
      on_cnt_q  <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      en_n_q    <= en_n_d;
      tick_q    <= tick_d;
      on_cnt_q  <= on_cnt_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  // Scan sequencing; abort outranks every dwell transition.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    en_n_d    = 1'b1;
    tick_d    = 1'b0;
    on_cnt_d  = on_cnt_q;
    blk_cnt_d = blk_cnt_q;

    case (state_q)
      ST_IDLE: begin
        on_cnt_d  = '0;
        blk_cnt_d = '0;
        if (!abort_c) begin
          state_d = ST_ON;
          sel_d   = low_sel_c;
          en_n_d  = 1'b0;
        end
      end

      ST_ON: begin
        if (abort_c) begin
          state_d   = ST_IDLE;
          on_cnt_d  = '0;
          blk_cnt_d = '0;
        end else if (!bus.digit_mask[sel_q] || (on_cnt_q == ON_LAST)) begin
          state_d   = ST_BLANK;
          on_cnt_d  = '0;
          blk_cnt_d = '0;
        end else begin
          en_n_d   = 1'b0;
          on_cnt_d = on_cnt_q + ON_W'(1);
        end
      end

      ST_BLANK: begin
        if (abort_c) begin
          state_d   = ST_IDLE;
          on_cnt_d  = '0;
          blk_cnt_d = '0;
        end else begin
          // Select advances at the end of the first dead-time cycle.
          if (blk_cnt_q == '0) begin
            sel_d  = nxt_sel_c;
            tick_d = (nxt_sel_c <= sel_q);
          end
          if (blk_cnt_q == BL_LAST) begin
            state_d   = ST_ON;
            en_n_d    = 1'b0;
            on_cnt_d  = '0;
            blk_cnt_d = '0;
          end else begin
            blk_cnt_d = blk_cnt_q + BL_W'(1);
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        on_cnt_d  = '0;
        blk_cnt_d = '0;
      end
    endcase
  end

  assign bus.sel        = sel_q;
  assign bus.en_n       = en_n_q;
  assign bus.frame_tick = tick_q;

endmodule
